// File: rtl/perf_counter_bank_pkg.sv
// perf_counter_bank_pkg: shared types and CTRL bit positions for the performance counter bank
package perf_counter_bank_pkg;
    typedef logic [15:0] lc3b_word;
    typedef logic [15:0] perf_off_t;
    localparam int PERF_CTRL_FREEZE = 0;
    localparam int PERF_CTRL_CLRALL = 1;
    localparam int PERF_MAX_CH = 16;
endpackage

// File: rtl/perf_counter_ch.sv
// perf_counter_ch: one event counter with clear priority, overflow pulse and wrap/saturate mode
module perf_counter_ch #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    input  logic         sat_mode,
    output logic [W-1:0] cnt,
    output logic         ovf_pulse
);
    assign ovf_pulse = inc & ~clr & (&cnt);
    always_ff @(posedge clk) begin
        if (reset || clr) cnt <= '0;
        else if (inc) cnt <= (ovf_pulse && sat_mode) ? cnt : cnt + 1'b1;
    end
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: memory-mapped bank of event counters with coherent hi-half snapshot reads
module perf_counter_bank
    import perf_counter_bank_pkg::*;
#(
    parameter int          NUM_CH    = 8,
    parameter int          CNT_WIDTH = 32,
    parameter logic [15:0] BASE_ADDR = 16'hFFC0,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] event_inc,
    input  logic [15:0]       mem_address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [15:0]       mem_wdata,
    output logic              addr_hit,
    output logic              mem_resp,
    output logic [15:0]       rdata
);
    perf_off_t   off;
    logic [3:0]  idx;
    logic        is_cnt, is_ctrl, is_ovf, wr, rd, clr_all, cnt_wr, freeze;
    logic [31:0] cnt_w [PERF_MAX_CH];
    logic [15:0] ovf_set, ovf, shadow_hi, rd_val;
    assign off      = mem_address - BASE_ADDR;
    assign addr_hit = off < perf_off_t'(2 * NUM_CH + 2);
    assign is_cnt   = off < perf_off_t'(2 * NUM_CH);
    assign is_ctrl  = off == perf_off_t'(2 * NUM_CH);
    assign is_ovf   = off == perf_off_t'(2 * NUM_CH + 1);
    assign idx      = off[4:1];
    assign wr       = addr_hit & mem_write;
    assign rd       = addr_hit & mem_read & ~mem_write;
    assign clr_all  = wr & is_ctrl & mem_wdata[PERF_CTRL_CLRALL];
    assign cnt_wr   = wr & is_cnt;
    for (genvar i = 0; i < PERF_MAX_CH; i++) begin : g_ch
        if (i < NUM_CH) begin : g_on
            logic [CNT_WIDTH-1:0] c;
            logic                 p;
            perf_counter_ch #(.W(CNT_WIDTH)) u_ch (
                .clk      (clk),
                .reset    (reset),
                .inc      (event_inc[i] & ~freeze),
                .clr      (clr_all | (cnt_wr & (idx == 4'(i)))),
                .sat_mode (SATURATE),
                .cnt      (c),
                .ovf_pulse(p)
            );
            assign cnt_w[i]   = 32'(c);
            assign ovf_set[i] = p;
        end else begin : g_off
            assign cnt_w[i]   = '0;
            assign ovf_set[i] = 1'b0;
        end
    end
    always_comb begin
        rd_val = is_cnt ? (off[0] ? shadow_hi : cnt_w[idx][15:0]) :
                 is_ctrl ? {15'h0, freeze} :
                 is_ovf ? ovf : 16'h0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_resp  <= 1'b0;
            rdata     <= 16'h0;
            shadow_hi <= 16'h0;
            freeze    <= 1'b0;
            ovf       <= 16'h0;
        end else begin
            mem_resp <= addr_hit & (mem_read | mem_write);
            rdata    <= rd ? rd_val : 16'h0;
            if (rd && is_cnt && !off[0]) shadow_hi <= cnt_w[idx][31:16];
            if (wr && is_ctrl) freeze <= mem_wdata[PERF_CTRL_FREEZE];
            // a same-cycle overflow re-sets a bit the write is clearing
            ovf <= (clr_all ? 16'h0 : (wr && is_ovf) ? ovf & ~mem_wdata : ovf) | ovf_set;
        end
    end
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: directed stimulus on three bank variants checked against a per-cycle behavioural model
module tb_perf_counter_bank;
    localparam logic [15:0] BASE = 16'hFFC0;
    localparam int WD [3] = '{32, 8, 8};
    localparam bit SAT [3] = '{1'b0, 1'b0, 1'b1};

    logic        clk = 1'b0, reset = 1'b1;
    logic [7:0]  event_inc = 8'h0;
    logic [15:0] mem_address = 16'h0, mem_wdata = 16'h0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic        hit [3], resp [3];
    logic [15:0] rdat [3];
    logic        ghit [3], gresp [3];
    logic [15:0] got [3];
    int          checks = 0, fails = 0;
    bit          live = 1'b0;

    longint unsigned mcnt [3][8];
    logic [15:0]     msh [3], movf [3], mrd [3];
    bit              mfrz [3], mresp [3];

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CH(8), .CNT_WIDTH(32), .BASE_ADDR(BASE), .SATURATE(1'b0)) u_w32 (
        .clk(clk), .reset(reset), .event_inc(event_inc), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .addr_hit(hit[0]), .mem_resp(resp[0]), .rdata(rdat[0]));
    perf_counter_bank #(.NUM_CH(8), .CNT_WIDTH(8), .BASE_ADDR(BASE), .SATURATE(1'b0)) u_w8 (
        .clk(clk), .reset(reset), .event_inc(event_inc), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .addr_hit(hit[1]), .mem_resp(resp[1]), .rdata(rdat[1]));
    perf_counter_bank #(.NUM_CH(8), .CNT_WIDTH(8), .BASE_ADDR(BASE), .SATURATE(1'b1)) u_s8 (
        .clk(clk), .reset(reset), .event_inc(event_inc), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .addr_hit(hit[2]), .mem_resp(resp[2]), .rdata(rdat[2]));

    task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
        checks++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s got=%h exp=%h at %0t", n, g, e, $time);
        end
    endtask

    function automatic void model_step();
        logic [15:0] off;
        bit h, w, r;
        int o;
        longint unsigned mx;
        off = mem_address - BASE;
        o = int'(off);
        h = o < 18;
        w = h && mem_write;
        r = h && mem_read && !mem_write;
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                for (int c = 0; c < 8; c++) mcnt[k][c] = 0;
                msh[k] = 0; movf[k] = 0; mfrz[k] = 0; mresp[k] = 0; mrd[k] = 0;
                continue;
            end
            mresp[k] = h && (mem_read || mem_write);
            mrd[k] = 16'h0;
            if (r) begin
                if (o < 16) mrd[k] = off[0] ? msh[k] : 16'(mcnt[k][o / 2]);
                else if (o == 16) mrd[k] = {15'h0, mfrz[k]};
                else mrd[k] = movf[k];
            end
            if (r && o < 16 && !off[0]) msh[k] = 16'(mcnt[k][o / 2] >> 16);
            if (w && o == 17) movf[k] = movf[k] & ~mem_wdata;
            if (w && o == 16 && mem_wdata[1]) movf[k] = 16'h0;
            mx = (64'd1 << WD[k]) - 1;
            for (int c = 0; c < 8; c++) begin
                if (w && ((o < 16 && o / 2 == c) || (o == 16 && mem_wdata[1]))) mcnt[k][c] = 0;
                else if (event_inc[c] && !mfrz[k]) begin
                    if (mcnt[k][c] == mx) begin
                        movf[k][c] = 1'b1;
                        mcnt[k][c] = SAT[k] ? mx : 0;
                    end else mcnt[k][c] = mcnt[k][c] + 1;
                end
            end
            if (w && o == 16) mfrz[k] = mem_wdata[0];
        end
    endfunction

    always @(posedge clk) begin
        model_step();
        live <= 1'b1;
    end

    always @(negedge clk) begin
        if (live) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("resp%0d", k), resp[k], mresp[k]);
                chk($sformatf("rdata%0d", k), rdat[k], mrd[k]);
                chk($sformatf("addr_hit%0d", k), hit[k], 32'(mem_address - BASE) < 18);
            end
        end
    end

    task automatic acc(input logic [15:0] a, input logic r, input logic w, input logic [15:0] d);
        @(posedge clk);
        #1;
        mem_address = a; mem_read = r; mem_write = w; mem_wdata = d;
        #1;
        for (int k = 0; k < 3; k++) ghit[k] = hit[k];
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            got[k] = rdat[k];
            gresp[k] = resp[k];
        end
    endtask

    task automatic pulse(input logic [7:0] m, input int n);
        @(posedge clk);
        #1;
        event_inc = m;
        repeat (n) @(posedge clk);
        #1;
        event_inc = 8'h0;
    endtask

    task automatic lit(input string n, input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        chk({n, "_w32"}, got[0], e0);
        chk({n, "_w8"}, got[1], e1);
        chk({n, "_s8"}, got[2], e2);
        chk({n, "_resp"}, gresp[0], 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_resp", resp[0], 0);
        chk("reset_rdata", rdat[0], 0);
        reset = 1'b0;

        pulse(8'h01, 5);
        acc(BASE, 1, 0, 0);
        lit("t1_lo0", 16'h0005, 16'h0005, 16'h0005);

        pulse(8'h02, 70000);
        acc(BASE + 2, 1, 0, 0);
        lit("t2_lo1", 16'h1170, 16'h0070, 16'h00FF);
        pulse(8'h02, 3);
        acc(BASE + 3, 1, 0, 0);
        lit("t2_hi1", 16'h0001, 16'h0000, 16'h0000);

        pulse(8'h01, 251);
        acc(BASE, 1, 0, 0);
        lit("t3_lo0", 16'h0100, 16'h0000, 16'h00FF);
        acc(BASE + 17, 1, 0, 0);
        lit("t3_ovf", 16'h0000, 16'h0003, 16'h0003);
        acc(BASE + 17, 0, 1, 16'h0001);
        acc(BASE + 17, 1, 0, 0);
        lit("t3_ovfclr", 16'h0000, 16'h0002, 16'h0002);

        acc(BASE + 16, 0, 1, 16'h0001);
        pulse(8'hFF, 10);
        acc(BASE, 1, 0, 0);
        lit("t4_frz0", 16'h0100, 16'h0000, 16'h00FF);
        acc(BASE + 2, 1, 0, 0);
        lit("t4_frz1", 16'h1173, 16'h0073, 16'h00FF);
        acc(BASE + 16, 1, 0, 0);
        lit("t4_ctrl", 16'h0001, 16'h0001, 16'h0001);
        acc(BASE + 16, 0, 1, 16'h0002);
        acc(BASE + 2, 1, 0, 0);
        lit("t4_clr1", 16'h0000, 16'h0000, 16'h0000);
        acc(BASE + 17, 1, 0, 0);
        lit("t4_clrovf", 16'h0000, 16'h0000, 16'h0000);
        acc(BASE + 16, 1, 0, 0);
        lit("t4_unfrz", 16'h0000, 16'h0000, 16'h0000);

        pulse(8'h04, 4);
        event_inc = 8'h04;
        acc(BASE + 4, 0, 1, 16'hFFFF);
        event_inc = 8'h00;
        acc(BASE + 4, 1, 0, 0);
        lit("t5_clr2", 16'h0000, 16'h0000, 16'h0000);
        pulse(8'h04, 2);
        acc(BASE + 4, 1, 0, 0);
        lit("t5_recount", 16'h0002, 16'h0002, 16'h0002);

        acc(BASE - 16'd1, 1, 0, 0);
        chk("t6_below_hit", ghit[0], 0);
        chk("t6_below_resp", gresp[0], 0);
        acc(BASE + 16'd18, 1, 0, 0);
        chk("t6_above_hit", ghit[0], 0);
        chk("t6_above_resp", gresp[0], 0);
        acc(BASE + 16'd17, 1, 0, 0);
        chk("t6_last_hit", ghit[0], 1);

        @(posedge clk);
        #1;
        mem_address = BASE; mem_read = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_resp", resp[0], 0);
        chk("t6_rst_rdata", rdat[0], 0);
        reset = 1'b0; mem_read = 1'b0;
        acc(BASE, 1, 0, 0);
        lit("t6_after_rst", 16'h0000, 16'h0000, 16'h0000);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
